// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract split into STAGES registered carry-chain slices,
// with carry, signed-overflow and zero flags and a valid/ready handshake on both sides.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             Clk_i,
  input  logic             Rst_i,
  input  logic [WIDTH-1:0] Number1_i,
  input  logic [WIDTH-1:0] Number2_i,
  input  logic             Carry_i,
  input  logic             Sub_i,
  input  logic             Valid_i,
  output logic             Ready_o,
  output logic [WIDTH-1:0] Result_o,
  output logic             Carry_o,
  output logic             Overflow_o,
  output logic             Zero_o,
  output logic             Valid_o,
  input  logic             Ready_i
);

  localparam int CHUNK = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_adder: WIDTH must be >= 2 and STAGES >= 1 must divide WIDTH");
  end

  // Handshake: an op enters on an edge where Valid_i & Ready_o and leaves on an edge
  // where Valid_o & Ready_i. The whole pipe moves as one (w_adv) and bubbles are kept.
  logic w_adv;

  logic             r_valid [STAGES];
  logic             r_sub   [STAGES];
  logic             r_carry [STAGES];
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic [WIDTH-1:0] r_res   [STAGES];
  logic             r_ovf;
  logic             r_zero;

  // Per-stage view of what the stage consumes this cycle.
  logic             w_valid_cur [STAGES];
  logic             w_sub_cur   [STAGES];
  logic             w_cin_cur   [STAGES];
  logic [WIDTH-1:0] w_a_cur     [STAGES];
  logic [WIDTH-1:0] w_b_cur     [STAGES];
  logic [WIDTH-1:0] w_res_cur   [STAGES];

  // Per-stage values that the stage register loads on an advancing edge.
  logic             w_valid_nxt [STAGES];
  logic             w_sub_nxt   [STAGES];
  logic             w_carry_nxt [STAGES];
  logic [WIDTH-1:0] w_a_nxt     [STAGES];
  logic [WIDTH-1:0] w_b_nxt     [STAGES];
  logic [WIDTH-1:0] w_res_nxt   [STAGES];
  logic             w_ovf_nxt;
  logic             w_zero_nxt;

  assign w_adv   = Ready_i | ~r_valid[STAGES-1];
  assign Ready_o = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] w_b_slice;
    logic [CHUNK:0]   w_sum;

    if (k == 0) begin : g_first
      assign w_a_cur[k]     = Number1_i;
      assign w_b_cur[k]     = Number2_i;
      assign w_sub_cur[k]   = Sub_i;
      // Subtract forces the +1 of the two's-complement negate; Carry_i is ignored then.
      assign w_cin_cur[k]   = Sub_i | Carry_i;
      assign w_valid_cur[k] = Valid_i & w_adv;
      assign w_res_cur[k]   = '0;
    end else begin : g_follow
      assign w_a_cur[k]     = r_a[k-1];
      assign w_b_cur[k]     = r_b[k-1];
      assign w_sub_cur[k]   = r_sub[k-1];
      assign w_cin_cur[k]   = r_carry[k-1];
      assign w_valid_cur[k] = r_valid[k-1];
      assign w_res_cur[k]   = r_res[k-1];
    end

    assign w_b_slice = w_b_cur[k][CHUNK-1:0] ^ {CHUNK{w_sub_cur[k]}};
    assign w_sum     = {1'b0, w_a_cur[k][CHUNK-1:0]} + {1'b0, w_b_slice}
                     + {{CHUNK{1'b0}}, w_cin_cur[k]};

    // Result slices enter at the top and shift down, so after the last stage slice 0
    // sits in the low bits and the word is fully assembled.
    assign w_res_nxt[k]   = (WIDTH'(w_sum[CHUNK-1:0]) << (WIDTH - CHUNK))
                          | (w_res_cur[k] >> CHUNK);
    assign w_carry_nxt[k] = w_sum[CHUNK];
    assign w_sub_nxt[k]   = w_sub_cur[k];
    assign w_valid_nxt[k] = w_valid_cur[k];

    if (k < STAGES - 1) begin : g_skew
      assign w_a_nxt[k] = w_a_cur[k] >> CHUNK;
      assign w_b_nxt[k] = w_b_cur[k] >> CHUNK;
    end else begin : g_last
      assign w_a_nxt[k] = '0;
      assign w_b_nxt[k] = '0;
      // a^b^sum at the MSB recovers the carry into the MSB.
      assign w_ovf_nxt  = w_a_cur[k][CHUNK-1] ^ w_b_slice[CHUNK-1]
                        ^ w_sum[CHUNK-1] ^ w_sum[CHUNK];
      assign w_zero_nxt = ~|w_res_nxt[k];
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_sub[k]   <= 1'b0;
        r_carry[k] <= 1'b0;
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_res[k]   <= '0;
      end
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= w_valid_nxt[k];
        r_sub[k]   <= w_sub_nxt[k];
        r_carry[k] <= w_carry_nxt[k];
        r_a[k]     <= w_a_nxt[k];
        r_b[k]     <= w_b_nxt[k];
        r_res[k]   <= w_res_nxt[k];
      end
      r_ovf  <= w_ovf_nxt;
      r_zero <= w_zero_nxt;
    end
  end

  assign Result_o   = r_res[STAGES-1];
  assign Carry_o    = r_carry[STAGES-1];
  assign Overflow_o = r_ovf;
  assign Zero_o     = r_zero;
  assign Valid_o    = r_valid[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed (8,4) sequence with a scoreboard queue plus
// free-running random streams on the (8,1), (8,8), (32,4) and (64,2) configurations.
module tb_pipelined_adder;

  localparam int W = 8;
  localparam int S = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic rst_sw;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT ----------------
  logic [W-1:0] number1, number2, result;
  logic         carry_in, sub, valid_in, ready_out;
  logic         carry_out, overflow, zero, valid_out, ready_in;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
    .Clk_i      (clk),
    .Rst_i      (rst),
    .Number1_i  (number1),
    .Number2_i  (number2),
    .Carry_i    (carry_in),
    .Sub_i      (sub),
    .Valid_i    (valid_in),
    .Ready_o    (ready_out),
    .Result_o   (result),
    .Carry_o    (carry_out),
    .Overflow_o (overflow),
    .Zero_o     (zero),
    .Valid_o    (valid_out),
    .Ready_i    (ready_in)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en    = 1'b0;
  bit lat_check = 1'b1;
  bit rst_done  = 1'b0;

  logic [W+2:0] exp_q[$];
  int           due_q[$];
  logic [W+2:0] m_exp;
  int           m_due;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Packed as {result, carry, overflow, zero}.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sb);
    logic [W-1:0] bb;
    logic [W:0]   s;
    logic         ov;
    bb = sb ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sb ? 1'b1 : cin)};
    ov = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    return {s[W-1:0], s[W], ov, (s[W-1:0] == '0)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic sb);
    @(negedge clk);
    number1  = a;
    number2  = b;
    carry_in = cin;
    sub      = sb;
    valid_in = 1'b1;
    #1;
    if (ready_out) begin
      exp_q.push_back(model(a, b, cin, sb));
      due_q.push_back(cyc + S);
    end
  endtask

  task automatic send_rand();
    send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    valid_in = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
    check(tag, 128'(exp_q.size()), 128'(0));
  endtask

  // Output monitor: a transfer happens on the next edge when valid_out & ready_in.
  always begin
    @(negedge clk);
    #2;
    if (mon_en && valid_out === 1'b1 && ready_in === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 128'(valid_out), 128'(0));
      end else begin
        m_exp = exp_q.pop_front();
        m_due = due_q.pop_front();
        check("result", 128'({result, carry_out, overflow, zero}), 128'(m_exp));
        if (lat_check) check("latency", 128'(cyc), 128'(m_due));
      end
    end
  end

  // ---------------- parameter sweep ----------------
  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int SW = (g == 0) ? 8 : (g == 1) ? 8 : (g == 2) ? 32 : 64;
    localparam int SS = (g == 0) ? 1 : (g == 1) ? 8 : (g == 2) ? 4 : 2;

    logic [SW-1:0] s_a, s_b, s_res;
    logic          s_cin, s_sub, s_vin, s_rdy, s_co, s_ov, s_z, s_vo;
    logic [SW+2:0] s_exp_q[$];
    int            s_due_q[$];
    bit            s_done = 1'b0;

    pipelined_adder #(.WIDTH(SW), .STAGES(SS)) u_sweep (
      .Clk_i      (clk),
      .Rst_i      (rst_sw),
      .Number1_i  (s_a),
      .Number2_i  (s_b),
      .Carry_i    (s_cin),
      .Sub_i      (s_sub),
      .Valid_i    (s_vin),
      .Ready_o    (s_rdy),
      .Result_o   (s_res),
      .Carry_o    (s_co),
      .Overflow_o (s_ov),
      .Zero_o     (s_z),
      .Valid_o    (s_vo),
      .Ready_i    (1'b1)
    );

    function automatic logic [SW+2:0] s_model(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                              input logic cin, input logic sb);
      logic [SW-1:0] bb;
      logic [SW:0]   s;
      logic          ov;
      bb = sb ? ~b : b;
      s  = {1'b0, a} + {1'b0, bb} + {{SW{1'b0}}, (sb ? 1'b1 : cin)};
      ov = (a[SW-1] == bb[SW-1]) && (s[SW-1] != a[SW-1]);
      return {s[SW-1:0], s[SW], ov, (s[SW-1:0] == '0)};
    endfunction

    initial begin
      s_vin = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
      wait (rst_done);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (s_due_q.size() > 0 && s_due_q[0] == cyc) begin
          check($sformatf("sweep%0d_valid", g), 128'(s_vo), 128'(1));
          check($sformatf("sweep%0d_result", g), 128'({s_res, s_co, s_ov, s_z}),
                128'(s_exp_q[0]));
          void'(s_exp_q.pop_front());
          void'(s_due_q.pop_front());
        end else begin
          check($sformatf("sweep%0d_idle", g), 128'(s_vo), 128'(0));
        end
        check($sformatf("sweep%0d_ready", g), 128'(s_rdy), 128'(1));
        s_vin = (i < 30) && ($urandom_range(0, 4) != 0);
        s_a   = SW'({$urandom(), $urandom()});
        s_b   = (i % 7 == 0) ? '1 : SW'({$urandom(), $urandom()});
        s_cin = 1'($urandom_range(0, 1));
        s_sub = 1'($urandom_range(0, 1));
        if (s_vin) begin
          s_exp_q.push_back(s_model(s_a, s_b, s_cin, s_sub));
          s_due_q.push_back(cyc + SS);
        end
      end
      s_vin = 1'b0;
      check($sformatf("sweep%0d_drain", g), 128'(s_exp_q.size()), 128'(0));
      s_done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; rst_sw = 1'b1;
    number1 = '0; number2 = '0; carry_in = 1'b0; sub = 1'b0;
    valid_in = 1'b0; ready_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; rst_sw = 1'b0;
    rst_done = 1'b1;
    mon_en = 1'b1;
    #1;
    check("reset_valid_o",    128'(valid_out), 128'(0));
    check("reset_result_o",   128'(result),    128'(0));
    check("reset_carry_o",    128'(carry_out), 128'(0));
    check("reset_overflow_o", 128'(overflow),  128'(0));
    check("reset_zero_o",     128'(zero),      128'(0));
    check("reset_ready_o",    128'(ready_out), 128'(1));

    // Carry out and zero flag.
    send(8'hFF, 8'h01, 1'b0, 1'b0);
    drain("add_zero_drain");

    // Signed overflow in both modes; Carry_i must be ignored in subtract.
    send(8'h80, 8'h01, 1'b1, 1'b1);
    send(8'h7F, 8'h00, 1'b1, 1'b0);
    drain("overflow_drain");

    // Back-to-back stream with mixed modes.
    for (int i = 0; i < 16; i++) send_rand();
    drain("stream_drain");

    // Fill the pipe, then hold off the consumer for 3 cycles.
    lat_check = 1'b0;
    for (int i = 0; i < S; i++) send_rand();
    @(negedge clk);
    valid_in = 1'b0;
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("bp_ready_o", 128'(ready_out), 128'(0));
      check("bp_valid_o", 128'(valid_out), 128'(1));
      if (exp_q.size() > 0)
        check("bp_hold", 128'({result, carry_out, overflow, zero}), 128'(exp_q[0]));
      else
        check("bp_queue", 128'(exp_q.size()), 128'(S));
    end
    @(negedge clk);
    ready_in = 1'b1;
    drain("bp_drain");
    lat_check = 1'b1;

    // One-cycle reset with three ops in flight: they must never appear.
    for (int i = 0; i < 3; i++) send_rand();
    @(negedge clk);
    valid_in = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    due_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_valid_o",  128'(valid_out), 128'(0));
    check("rst_mid_result_o", 128'(result),    128'(0));
    repeat (8) @(negedge clk);
    send(8'h12, 8'h34, 1'b0, 1'b0);
    drain("post_rst_drain");

    for (int i = 0; i < 500 && !(g_sweep[0].s_done && g_sweep[1].s_done &&
                                 g_sweep[2].s_done && g_sweep[3].s_done); i++)
      @(negedge clk);
    check("sweep_done", 128'(g_sweep[0].s_done & g_sweep[1].s_done &
                             g_sweep[2].s_done & g_sweep[3].s_done), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined successor to the combinational carry-chain adder. It splits a WIDTH-bit add/subtract into STAGES registered carry-chain slices and sustains one operation per cycle at a fixed latency of STAGES cycles. It also produces carry, signed-overflow and zero flags, and supports backpressure with a valid/ready handshake on both sides. It sits in the datapath wherever a wide adder would otherwise break timing.

## Interface
- WIDTH, 32: operand/result width; legal values are ≥ 2.
- STAGES, 4: pipeline depth. Must be ≥ 1 and divide WIDTH; elaboration fails otherwise.
- Clk_i  in  1  single clock; all state updates on the rising edge.
- Rst_i  in  1  reset; synchronous, active-high.
- Number1_i  in  WIDTH  operand A.
- Number2_i  in  WIDTH  operand B.
- Carry_i  in  1  carry-in; used in add mode only.
- Sub_i  in  1  0 = add, 1 = subtract.
- Valid_i  in  1  input operation valid.
- Ready_o  out  1  pipeline can accept an input this cycle.
- Result_o  out  WIDTH  sum/difference, modulo 2^WIDTH.
- Carry_o  out  1  carry out of the MSB; in subtract mode, 1 = no borrow.
- Overflow_o  out  1  two's-complement signed overflow.
- Zero_o  out  1  Result_o == 0.
- Valid_o  out  1  output fields valid.
- Ready_i  in  1  downstream accepts output.

## Operation
- CHUNK = WIDTH/STAGES. Stage k (0-based) adds bit slice [k·CHUNK +: CHUNK] using the carry registered by stage k-1. Stage 0 uses the effective carry-in.
- Add mode: computes A + B + Carry_i.
- Subtract mode: computes A + ~B + 1. Carry_i is ignored.
- Operand slices for stage k are carried forward in skew registers until stage k consumes them. Result slices already computed are carried forward in de-skew registers, so all output fields of one operation appear together.
- The Sub_i mode travels with its operation and is never re-sampled.
- Overflow_o = carry into MSB XOR carry out of MSB. This is computed in the last stage.
- Zero_o is computed from the final assembled result.
- Each stage holds a valid bit.
- Global advance signal: adv = Ready_i | ~Valid_o. Ready_o = adv.
- When adv = 1, every stage register loads from its predecessor. Stage 0 loads the inputs and takes its valid bit from Valid_i & Ready_o.
- When adv = 0, all stage registers and valid bits hold, and Ready_o = 0.
- Bubbles (invalid stages) are not collapsed.
- Reset: all valid bits clear, and all output data/flag registers go to 0. Reset value of every output is 0, except Ready_o, which is 1 because Valid_o = 0.
- Reset mid-operation: in-flight operations are discarded. Valid_o = 0 from the cycle after the reset edge, and nothing is emitted afterwards for those operations.

## Timing
- Acceptance occurs at edge E when Valid_i & Ready_o.
- With Ready_i held at 1, the result is registered at edge E+STAGES-1. Valid_o and the data are high in the following cycle, so latency is STAGES cycles.
- STAGES = 1 gives a single registered adder with 1-cycle latency.
- Throughput is 1 op/cycle with no stalls.
- Output fields are registered only; there is no combinational path from Number*_i to Result_o.
- Ready_o depends combinationally on Ready_i and Valid_o only.
- While Valid_o = 1 and Ready_i = 0, all outputs are stable and no operation is lost or duplicated.
- Transfer out occurs on an edge where Valid_o & Ready_i.
- Simultaneous input acceptance and output transfer in the same cycle is legal and required.
- Rst_i has priority over all handshake activity in the same edge.

## Test plan
- Add with carry and zero (WIDTH=8, STAGES=4): A=0xFF, B=0x01, Carry_i=0, Sub_i=0, accepted at edge 0 → exactly 4 cycles later Valid_o=1, Result_o=0x00, Carry_o=1, Zero_o=1, Overflow_o=0.
- Subtract with overflow (WIDTH=8, STAGES=4): A=0x80, B=0x01, Sub_i=1, Carry_i=1 (ignored) → Result_o=0x7F, Carry_o=1, Overflow_o=1, Zero_o=0. Add A=0x7F, B=0x00, Carry_i=1 → Result_o=0x80, Overflow_o=1, Carry_o=0.
- Streaming: 16 random operations on consecutive cycles with Ready_i=1 → 16 consecutive Valid_o cycles matching a reference model in order, with modes mixed per operation.
- Backpressure: Ready_i=0 for 3 cycles while Valid_o=1 and the pipeline is full → Ready_o=0 and outputs frozen for all 3 cycles. After release, all results emerge in order with no loss or duplication.
- Reset mid-stream: assert Rst_i for 1 cycle with 3 operations in flight → Valid_o=0 and Result_o=0 the next cycle, and none of the 3 operations is ever emitted. A new operation issued afterwards completes with 4-cycle latency.
- Parameter sweep: (WIDTH, STAGES) ∈ {(8,1), (8,8), (32,4), (64,2)} with exhaustive/random operands → matches the model, and latency equals STAGES in every case.
